// File: rtl/atanhx_4_hw.sv
// atanhx_4_hw: three-stage piecewise-constant approximation of atanh(x) for
// IEEE-754 single-precision operands, with valid/ready handshakes on both
// sides. Special operands (zero, |x|=1, |x|>1/Inf/NaN, tiny |x|) bypass the
// segment table but travel through the same three stages, so every result
// has identical latency and results leave in input order.
module atanhx_4_hw #(
  parameter int K              = 4,
  parameter int DWIDTH         = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int BIAS           = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] y,
  output logic              out_invalid
);

  localparam int MAN_W = DWIDTH - 1 - EXPONENT_WIDTH;
  localparam int SEG_W = (K > 1) ? $clog2(K) : 1;

  // Exponent landmarks: |x| = 1.0, last exponent of the segment path, and
  // the largest exponent that is passed straight through (|x| < 0.125).
  localparam logic [EXPONENT_WIDTH-1:0] EXP_ONE      = EXPONENT_WIDTH'(BIAS);
  localparam logic [EXPONENT_WIDTH-1:0] EXP_HALF     = EXPONENT_WIDTH'(BIAS - 1);
  localparam logic [EXPONENT_WIDTH-1:0] EXP_PASS_MAX = EXPONENT_WIDTH'(BIAS - 4);
  localparam logic [EXPONENT_WIDTH-1:0] EXP_ZERO     = {EXPONENT_WIDTH{1'b0}};

  // Segment boundaries on q = floor(|x| * 256).
  localparam logic [7:0] SEG_B1 = 8'd80;
  localparam logic [7:0] SEG_B2 = 8'd160;
  localparam logic [7:0] SEG_B3 = 8'd224;

  localparam logic [DWIDTH-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [DWIDTH-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [DWIDTH-1:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_ONE  = 3'd1,
    CLS_INV  = 3'd2,
    CLS_PASS = 3'd3,
    CLS_SEG  = 3'd4
  } cls_e;

  // Segment value table (magnitudes; the operand sign is applied later).
  function automatic logic [DWIDTH-1:0] seg_value(input logic [SEG_W-1:0] seg);
    logic [DWIDTH-1:0] val;
    case (seg)
      SEG_W'(0): val = 32'h3E60_0000;  // 0.21875
      SEG_W'(1): val = 32'h3F00_0000;  // 0.5
      SEG_W'(2): val = 32'h3F80_0000;  // 1.0
      SEG_W'(3): val = 32'h3FE0_0000;  // 1.75
      default:   val = 32'h3FE0_0000;
    endcase
    return val;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: every stage moves together whenever the output slot is free
  // or is being drained this cycle.
  // ---------------------------------------------------------------------------
  logic adv_s;
  logic out_valid_r;
  logic [DWIDTH-1:0] y_r;
  logic out_invalid_r;

  assign adv_s       = ~out_valid_r | out_ready;
  assign in_ready    = adv_s;
  assign out_valid   = out_valid_r;
  assign y           = y_r;
  assign out_invalid = out_invalid_r;

  // ---------------------------------------------------------------------------
  // Stage 1: classify the incoming operand.
  // ---------------------------------------------------------------------------
  logic [EXPONENT_WIDTH-1:0] in_exp_s;
  logic [MAN_W-1:0]          in_man_s;
  cls_e                      in_cls_s;

  assign in_exp_s = x[DWIDTH-2 -: EXPONENT_WIDTH];
  assign in_man_s = x[MAN_W-1:0];

  // Operand class, first matching rule wins.
  always_comb begin
    in_cls_s = CLS_PASS;
    if (in_exp_s == EXP_ZERO) begin
      in_cls_s = CLS_ZERO;
    end else if ((in_exp_s == EXP_ONE) && (in_man_s == {MAN_W{1'b0}})) begin
      in_cls_s = CLS_ONE;
    end else if (in_exp_s >= EXP_ONE) begin
      in_cls_s = CLS_INV;
    end else if (in_exp_s <= EXP_PASS_MAX) begin
      in_cls_s = CLS_PASS;
    end else begin
      in_cls_s = CLS_SEG;
    end
  end

  logic              s1_valid_r;
  logic [DWIDTH-1:0] s1_x_r;
  cls_e              s1_cls_r;

  // Stage 1 register: operand and its class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= {DWIDTH{1'b0}};
      s1_cls_r   <= CLS_ZERO;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_x_r     <= x;
      s1_cls_r   <= in_cls_s;
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_x_r     <= s1_x_r;
      s1_cls_r   <= s1_cls_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fixed-point magnitude and segment comparison.
  // ---------------------------------------------------------------------------
  logic [EXPONENT_WIDTH-1:0] s1_exp_s;
  logic [7:0]                frac_s;
  logic [EXPONENT_WIDTH-1:0] shift_s;
  logic [7:0]                q_s;
  logic [SEG_W-1:0]          seg_s;

  assign s1_exp_s = s1_x_r[DWIDTH-2 -: EXPONENT_WIDTH];
  assign frac_s   = {1'b1, s1_x_r[MAN_W-1 -: 7]};
  assign shift_s  = EXP_HALF - s1_exp_s;

  // q = floor(|x| * 256) and its segment index; only meaningful on the
  // segment path, where the shift is 0..2.
  always_comb begin
    q_s   = 8'd0;
    seg_s = SEG_W'(0);
    if (s1_cls_r == CLS_SEG) begin
      q_s = frac_s >> shift_s;
    end else begin
      q_s = 8'd0;
    end
    if (q_s < SEG_B1) begin
      seg_s = SEG_W'(0);
    end else if (q_s < SEG_B2) begin
      seg_s = SEG_W'(1);
    end else if (q_s < SEG_B3) begin
      seg_s = SEG_W'(2);
    end else begin
      seg_s = SEG_W'(3);
    end
  end

  logic              s2_valid_r;
  logic [DWIDTH-1:0] s2_x_r;
  cls_e              s2_cls_r;
  logic [SEG_W-1:0]  s2_seg_r;

  // Stage 2 register: operand, class and segment index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_x_r     <= {DWIDTH{1'b0}};
      s2_cls_r   <= CLS_ZERO;
      s2_seg_r   <= SEG_W'(0);
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_x_r     <= s1_x_r;
      s2_cls_r   <= s1_cls_r;
      s2_seg_r   <= seg_s;
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_x_r     <= s2_x_r;
      s2_cls_r   <= s2_cls_r;
      s2_seg_r   <= s2_seg_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: select the final word and register the outputs.
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] y_s;
  logic              inv_s;
  logic [DWIDTH-1:0] seg_word_s;
  logic              s2_sign_s;

  assign s2_sign_s = s2_x_r[DWIDTH-1];

  // Result word per class; segment results take the operand's sign.
  always_comb begin
    y_s        = QNAN;
    inv_s      = 1'b0;
    seg_word_s = seg_value(s2_seg_r);
    case (s2_cls_r)
      CLS_ZERO: begin
        y_s   = {s2_sign_s, {(DWIDTH-1){1'b0}}};
        inv_s = 1'b0;
      end
      CLS_ONE: begin
        y_s   = s2_sign_s ? NEG_INF : POS_INF;
        inv_s = 1'b0;
      end
      CLS_INV: begin
        y_s   = QNAN;
        inv_s = 1'b1;
      end
      CLS_PASS: begin
        y_s   = s2_x_r;
        inv_s = 1'b0;
      end
      CLS_SEG: begin
        y_s   = {s2_sign_s, seg_word_s[DWIDTH-2:0]};
        inv_s = 1'b0;
      end
      default: begin
        y_s   = QNAN;
        inv_s = 1'b1;
      end
    endcase
  end

  // Output register: result, invalid flag and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      y_r           <= {DWIDTH{1'b0}};
      out_invalid_r <= 1'b0;
    end else if (adv_s) begin
      out_valid_r   <= s2_valid_r;
      y_r           <= y_s;
      out_invalid_r <= inv_s;
    end else begin
      out_valid_r   <= out_valid_r;
      y_r           <= y_r;
      out_invalid_r <= out_invalid_r;
    end
  end

endmodule

// File: tb/tb_atanhx_4_hw.sv
// Testbench for atanhx_4_hw: scoreboard of expected results pushed on each
// accepted operand and popped on each output transfer.
module tb_atanhx_4_hw;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        out_invalid;

  atanhx_4_hw dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        inv;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   out_cnt = 0;
  logic chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: magnitude computed in real arithmetic.
  function automatic logic [32:0] model(input logic [31:0] v);
    logic       s;
    int         e;
    logic [22:0] m;
    real        mag;
    logic [31:0] r;
    s = v[31];
    e = int'(v[30:23]);
    m = v[22:0];
    if (e == 0) return {1'b0, s, 31'd0};
    if (e == 127 && m == 23'd0) return {1'b0, (s ? 32'hFF800000 : 32'h7F800000)};
    if (e >= 127) return {1'b1, 32'h7FC00000};
    if (e <= 123) return {1'b0, v};
    mag = 1.0 + real'(m) / 8388608.0;
    for (int i = e; i < 127; i++) mag = mag / 2.0;
    mag = mag * 256.0;
    if (mag < 80.0)       r = 32'h3E600000;
    else if (mag < 160.0) r = 32'h3F000000;
    else if (mag < 224.0) r = 32'h3F800000;
    else                  r = 32'h3FE00000;
    return {1'b0, s, r[30:0]};
  endfunction

  // Output monitor: pops the scoreboard on every output transfer.
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      out_cnt = out_cnt + 1;
      if (sb.size() == 0) begin
        check_val("spurious_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("y", y, e.y);
        check_val("out_invalid", {31'd0, out_invalid}, {31'd0, e.inv});
        if (chk_lat) check_val("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] ey, input logic einv);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    @(negedge clk);
    x = v;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      ok = in_ready;
    end
    if (ok) begin
      e.y = ey; e.inv = einv; e.cyc = cyc;
      sb.push_back(e);
    end else begin
      check_val("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_model(input logic [31:0] v);
    logic [32:0] r;
    r = model(v);
    send(v, r[31:0], r[32]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check_val("drain", 32'(sb.size()), 32'd0);
  endtask

  // Spec vectors: x, y, invalid.
  logic [64:0] vec [0:11] = '{
    {32'h3F000000, 32'h3F000000, 1'b0}, {32'hBF400000, 32'hBF800000, 1'b0},
    {32'h3F700000, 32'h3FE00000, 1'b0}, {32'h3E800000, 32'h3E600000, 1'b0},
    {32'h3F800000, 32'h7F800000, 1'b0}, {32'hBF800000, 32'hFF800000, 1'b0},
    {32'h40000000, 32'h7FC00000, 1'b1}, {32'h7F800000, 32'h7FC00000, 1'b1},
    {32'h7FC00001, 32'h7FC00000, 1'b1}, {32'h3D800000, 32'h3D800000, 1'b0},
    {32'h80000000, 32'h80000000, 1'b0}, {32'h00000001, 32'h00000000, 1'b0}
  };

  // Segment and class boundaries, hand-computed.
  logic [64:0] bnd [0:11] = '{
    {32'h3E9E0000, 32'h3E600000, 1'b0}, {32'h3EA00000, 32'h3F000000, 1'b0},
    {32'h3F1F0000, 32'h3F000000, 1'b0}, {32'h3F200000, 32'h3F800000, 1'b0},
    {32'h3F5F0000, 32'h3F800000, 1'b0}, {32'h3F600000, 32'h3FE00000, 1'b0},
    {32'h3DFFFFFF, 32'h3DFFFFFF, 1'b0}, {32'h3E000000, 32'h3E600000, 1'b0},
    {32'hBEA00000, 32'hBF000000, 1'b0}, {32'h00400000, 32'h00000000, 1'b0},
    {32'h3F7FFFFF, 32'h3FE00000, 1'b0}, {32'h3F800001, 32'h7FC00000, 1'b1}
  };

  logic [31:0] stall_ops [0:3] = '{32'h3F000000, 32'hBF400000, 32'h3F700000, 32'h3E800000};
  logic [31:0] stall_exp [0:3] = '{32'h3F000000, 32'hBF800000, 32'h3FE00000, 32'h3E600000};

  initial begin
    int o0;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; x = 32'd0; out_ready = 1'b1;
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_y", y, 32'd0);
    check_val("rst_out_invalid", {31'd0, out_invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check_val("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Directed spec vectors streamed back to back, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) send(vec[i][64:33], vec[i][32:1], vec[i][0]);
    idle();
    drain();
    for (int i = 0; i < 12; i++) send(bnd[i][64:33], bnd[i][32:1], bnd[i][0]);
    idle();
    drain();
    chk_lat = 1'b0;

    // Stall: three accepted, fourth blocked while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(stall_ops[i], stall_exp[i], 1'b0);
    @(negedge clk);
    x = stall_ops[3];
    in_valid = 1'b1;
    #4;
    check_val("stall_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("stall_y0", y, 32'h3F000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      check_val("stall_y_held", y, 32'h3F000000);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("stall_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    o0 = out_cnt;
    @(negedge clk);
    out_ready = 1'b1;
    #4;
    check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
    e.y = stall_exp[3]; e.inv = 1'b0; e.cyc = cyc;
    sb.push_back(e);
    idle();
    drain();
    check_val("stall_out_count", 32'(out_cnt - o0), 32'd4);

    // Reset with two operands in flight (one at the output, one in S2).
    @(negedge clk);
    x = 32'h3F000000; in_valid = 1'b1;
    @(negedge clk);
    x = 32'hBF400000;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_y", y, 32'd0);
    check_val("midrst_out_invalid", {31'd0, out_invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check_val("in_ready_after_midrst", {31'd0, in_ready}, 32'd1);
    o0 = out_cnt;
    repeat (12) @(negedge clk);
    check_val("no_stale_result", 32'(out_cnt - o0), 32'd0);

    // Random operands with random back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0]  ex;
          logic [22:0] mn;
          int          pick;
          pick = $urandom_range(0, 9);
          if (pick == 0)      ex = 8'd0;
          else if (pick == 1) ex = 8'd255;
          else                ex = 8'($urandom_range(120, 129));
          mn = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
          send_model({1'($urandom_range(0, 1)), ex, mn});
        end
        idle();
      end
      begin
        repeat (60) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
